// File: rtl/sys_bus_init_pkg.sv
// sys_bus_init_pkg: shared types for the sys_bus command initiator.
//   cmd_t   - one buffered bus command (direction, byte address, write data)
//   rsp_t   - one returned response (read data, error flag, timeout flag)
//   state_t - initiator FSM state, also exported on the debug port
package sys_bus_init_pkg;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Width of the WAIT-cycle timeout counter; TW must fit in it.
    localparam int unsigned TMO_W = 16;

endpackage

// File: rtl/sys_bus_if.sv
// sys_bus_if: single-master system bus towards register-array responders.
//   clk   - bus clock (same as the initiator clock)
//   addr  - byte address, driven by the master
//   wdata - write data, driven by the master
//   wen   - one-cycle write strobe
//   ren   - one-cycle read strobe
//   rdata - read data from the responder, valid with ack
//   ack   - responder completed the access
//   err   - responder rejected the access
//
// Handshake: the master raises exactly one of wen/ren for a single cycle with
// addr/wdata valid; the responder answers later with a one-cycle ack or err
// (rdata meaningful only with ack on a read). The master keeps at most one
// access outstanding and ignores ack/err when it is not waiting for one.
interface sys_bus_if (
    input logic clk
);
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport m (
        input  clk,
        input  rdata,
        input  ack,
        input  err,
        output addr,
        output wdata,
        output wen,
        output ren
    );

    modport s (
        input  clk,
        input  addr,
        input  wdata,
        input  wen,
        input  ren,
        output rdata,
        output ack,
        output err
    );
endinterface

// File: rtl/sys_bus_init_fifo.sv
// sys_bus_init_fifo: synchronous FIFO of cmd_t, DEPTH entries (power of 2).
//   clk, rst - clock, synchronous active-high reset (empties the FIFO)
//   push/din - write an entry; ignored while full
//   pop/dout - dout shows the head entry; pop removes it, ignored while empty
//   full, empty, level - occupancy status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sys_bus_init_fifo
    import sys_bus_init_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  cmd_t        din,
    input  logic        pop,
    output cmd_t        dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    cmd_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read once the pointers say valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/sys_bus_init_seq.sv
// sys_bus_init_seq: command-driven initiator for sys_bus_if.
// Commands are buffered in a CD-deep FIFO, issued one at a time as a single
// wen/ren strobe, and each produces exactly one response on the rsp port.
//   clk, rst              - clock, synchronous active-high reset
//   cmd_vld/cmd_rdy       - command handshake (cmd_rdy = FIFO not full)
//   cmd_wr/addr/wdata     - command payload (1 = write)
//   rsp_vld/rsp_rdy       - response handshake; fields hold until accepted
//   rsp_rdata/err/tmo     - response payload
//   busy                  - registered: work buffered or in flight
//   dbg_state             - current FSM state
//   bus                   - sys_bus_if master modport
// Build option: SYS_BUS_INIT_TIMEOUT_EN adds a TW-cycle WAIT timeout; without
// it WAIT lasts until ack/err and rsp_tmo is always 0.
module sys_bus_init_seq
    import sys_bus_init_pkg::*;
#(
    parameter int unsigned CD = 8,
    parameter int unsigned TW = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_tmo,
    output logic        busy,
    output state_t      dbg_state,
    sys_bus_if.m        bus
);

    localparam int unsigned LW = $clog2(CD) + 1;

    state_t          state_q;
    state_t          state_d;
    cmd_t            cur_q;
    rsp_t            rsp_q;
    rsp_t            rsp_d;
    logic            busy_q;
    logic            busy_d;
    logic            tmo_hit;

    cmd_t            fifo_din;
    cmd_t            fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [LW-1:0]   fifo_level;
    logic [LW-1:0]   level_d;
    logic            push_ok;

    assign fifo_din = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_rdy  = !fifo_full;
    assign push_ok  = cmd_vld && !fifo_full;

    sys_bus_init_fifo #(
        .DEPTH (CD)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_vld),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef SYS_BUS_INIT_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q;

    // Counts completed WAIT cycles; the TW-th silent WAIT cycle times out.
    assign tmo_hit = (state_q == WAIT) && (tmo_cnt_q == TMO_W'(TW - 1));

    always_ff @(posedge clk) begin
        if (rst || state_q == ISSUE) begin
            tmo_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    // TW has no effect without the timeout counter.
    logic unused_tw;
    assign unused_tw = (TW != 0);
    assign tmo_hit   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rsp_d    = rsp_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // ack/err are deliberately not looked at while strobing.
                state_d = WAIT;
            end
            WAIT: begin
                // A real answer in the last timeout cycle still wins.
                if (bus.ack || bus.err) begin
                    rsp_d.rdata = (!cur_q.wr && !bus.err) ? bus.rdata : 32'h0;
                    rsp_d.err   = bus.err;
                    rsp_d.tmo   = 1'b0;
                    state_d     = RESP;
                end else if (tmo_hit) begin
                    rsp_d.rdata = 32'h0;
                    rsp_d.err   = 1'b0;
                    rsp_d.tmo   = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_rdy) begin
                    rsp_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy is registered from next-cycle occupancy so it drops exactly one
    // cycle after the final response handshake.
    always_comb begin
        level_d = fifo_level + LW'(push_ok) - LW'(fifo_pop);
        busy_d  = (state_d != IDLE) || (level_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rsp_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            busy_q  <= busy_d;
            if (fifo_pop) begin
                cur_q <= fifo_dout;
            end
        end
    end

    // addr/wdata hold the last issued command until the next ISSUE.
    assign bus.addr  = cur_q.addr;
    assign bus.wdata = cur_q.wdata;
    assign bus.wen   = (state_q == ISSUE) && cur_q.wr;
    assign bus.ren   = (state_q == ISSUE) && !cur_q.wr;

    assign rsp_vld   = (state_q == RESP);
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;
    assign rsp_tmo   = rsp_q.tmo;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sys_bus_init_seq.sv
// tb_sys_bus_init_seq: self-checking bench for sys_bus_init_seq (CD=8, TW=16).
// A register-array responder answers strobes after a programmable delay with
// ack, err, or never. Works with and without SYS_BUS_INIT_TIMEOUT_EN.
module tb_sys_bus_init_seq;
    import sys_bus_init_pkg::*;

    localparam int CD = 8;
    localparam int TW = 16;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rmode;      // 0 ack, 1 err, 2 silent
        int          dly;        // strobe-to-answer cycles
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic        cmd_wr;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_tmo;
    logic        busy;
    state_t      dbg_state;

    sys_bus_if bus (.clk(clk));

    sys_bus_init_seq #(.CD(CD), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_vld   (cmd_vld),
        .cmd_rdy   (cmd_rdy),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_tmo   (rsp_tmo),
        .busy      (busy),
        .dbg_state (dbg_state),
        .bus       (bus)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- responder ----------------
    int          rmode = 0;
    int          rdelay = 1;
    bit          inject_req = 1'b0;
    bit          inject_seen = 1'b0;
    int          pend = 0;
    bit          pend_err = 1'b0;
    bit          mem_init = 1'b0;
    logic [31:0] mem [16];
    logic [3:0]  last_idx = '0;
    int          strobe_cnt = 0;
    int          strobe_cyc = 0;
    logic        strobe_wr = 1'b0;
    logic [31:0] strobe_addr = '0;
    logic [31:0] strobe_wdata = '0;

    initial begin
        bus.ack   = 1'b0;
        bus.err   = 1'b0;
        bus.rdata = '0;
    end

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] = 32'h1111_0000 + 32'(i);
            mem[1]   = 32'h1234_5678;
            mem_init = 1'b1;
        end
        bus.ack = 1'b0;
        bus.err = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                if (pend_err) bus.err = 1'b1;
                else          bus.ack = 1'b1;
                bus.rdata = mem[last_idx];
            end
        end
        if (inject_req != inject_seen) begin
            inject_seen = inject_req;
            bus.ack     = 1'b1;
            bus.rdata   = mem[last_idx];
        end
        if (bus.wen || bus.ren) begin
            strobe_cnt++;
            strobe_cyc   = cyc;
            strobe_wr    = bus.wen;
            strobe_addr  = bus.addr;
            strobe_wdata = bus.wdata;
            last_idx     = bus.addr[5:2];
            if (bus.wen) mem[bus.addr[5:2]] = bus.wdata;
            if (rmode != 2) begin
                pend     = rdelay;
                pend_err = (rmode == 1);
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    logic [33:0] exp_q[$];
    logic [31:0] exp_mem [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wen"},       bus.wen, 0);
        check({tag, "_ren"},       bus.ren, 0);
        check({tag, "_addr"},      bus.addr, 0);
        check({tag, "_wdata"},     bus.wdata, 0);
        check({tag, "_rsp_vld"},   rsp_vld, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_err"},   rsp_err, 0);
        check({tag, "_rsp_tmo"},   rsp_tmo, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_cmd_rdy"},   cmd_rdy, 1);
        check({tag, "_state"},     dbg_state, IDLE);
    endtask

    // ---------------- drivers ----------------
    task automatic do_txn(input vec_t v, input int idx);
        int t0;
        int s0;
        bit seen;
        string tag;
        tag    = $sformatf("v%0d", idx);
        rmode  = v.rmode;
        rdelay = v.dly;
        @(negedge clk);
        cmd_wr    = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_vld   = 1'b1;
        t0        = cyc;
        s0        = strobe_cnt;
        check({tag, "_cmd_rdy"}, cmd_rdy, 1);
        @(negedge clk);
        cmd_vld = 1'b0;
        seen    = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (rsp_vld) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_rsp_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_rsp_latency"}, cyc - t0, 3 + v.dly);
            check({tag, "_strobe_cnt"},  strobe_cnt - s0, 1);
            check({tag, "_strobe_cyc"},  strobe_cyc - t0, 2);
            check({tag, "_strobe_wr"},   strobe_wr, v.wr);
            check({tag, "_strobe_addr"}, strobe_addr, v.addr);
            if (v.wr) check({tag, "_strobe_wdata"}, strobe_wdata, v.wdata);
            check({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
            check({tag, "_err"},   rsp_err, v.exp_err);
            check({tag, "_tmo"},   rsp_tmo, 0);
            rsp_rdy = 1'b1;
            @(negedge clk);
            rsp_rdy = 1'b0;
            check({tag, "_vld_drop"}, rsp_vld, 0);
            check({tag, "_busy_drop"}, busy, 0);
        end
        if (v.wr) exp_mem[v.addr[5:2]] = v.wdata;
    endtask

    // ---------------- test ----------------
    vec_t vecs [8];

    initial begin
        int          t0;
        int          s0;
        int          pushed;
        int          got;
        int          prev;
        int          vld_cnt;
        bit          seen;
        logic [33:0] e;

        rst       = 1'b1;
        cmd_vld   = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_rdy   = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'h1111_0000 + 32'(i);
        exp_mem[1] = 32'h1234_5678;

        vecs[0] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 0, 1, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,         0, 1, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0008, 32'h0,         0, 3, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0004, 32'h0,         1, 1, 32'h0,         1'b1};
        vecs[4] = '{1'b1, 32'h0000_000C, 32'hA5A5_0F0F, 1, 2, 32'h0,         1'b1};
        vecs[5] = '{1'b0, 32'h0000_000C, 32'h0,         0, 1, 32'hA5A5_0F0F, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_003C, 32'h0000_0001, 0, 1, 32'h0,         1'b0};
        vecs[7] = '{1'b0, 32'h0000_003C, 32'h0,         0, 2, 32'h0000_0001, 1'b0};

        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) do_txn(vecs[i], i);

        // ---- no answer from the responder ----
        rmode = 2;
        @(negedge clk);
        cmd_wr = 1'b0; cmd_addr = 32'h4; cmd_wdata = '0; cmd_vld = 1'b1;
        t0 = cyc;
        @(negedge clk);
        cmd_vld = 1'b0;
`ifdef SYS_BUS_INIT_TIMEOUT_EN
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (rsp_vld) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("tmo_seen", seen, 1);
        check("tmo_latency", cyc - t0, 3 + TW);
        check("tmo_flag", rsp_tmo, 1);
        check("tmo_err", rsp_err, 0);
        check("tmo_rdata", rsp_rdata, 0);
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
        repeat (2) @(negedge clk);
        inject_req = ~inject_req;
        vld_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_vld) vld_cnt++;
        end
        check("late_ack_rsp", vld_cnt, 0);
        check("late_ack_state", dbg_state, IDLE);
`else
        repeat (40) @(negedge clk);
        check("notmo_state", dbg_state, WAIT);
        check("notmo_vld", rsp_vld, 0);
        check("notmo_tmo", rsp_tmo, 0);
        inject_req = ~inject_req;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_vld) begin
                seen = 1'b1;
                break;
            end
        end
        check("notmo_seen", seen, 1);
        check("notmo_rdata", rsp_rdata, 32'h1234_5678);
        check("notmo_err", rsp_err, 0);
        check("notmo_tmo_rsp", rsp_tmo, 0);
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
`endif

        // ---- nine commands against a stalled response port ----
        rmode  = 0;
        rdelay = 1;
        s0     = strobe_cnt;
        pushed = 0;
        for (int k = 0; k < 40 && pushed < 9; k++) begin
            @(negedge clk);
            if (cmd_rdy) begin
                cmd_wr    = pushed[0];
                cmd_addr  = 32'(pushed * 4);
                cmd_wdata = pushed[0] ? (32'hC0DE_0000 + 32'(pushed)) : 32'h0;
                cmd_vld   = 1'b1;
                if (pushed[0]) begin
                    exp_q.push_back(34'h0);
                    exp_mem[pushed] = 32'hC0DE_0000 + 32'(pushed);
                end else begin
                    exp_q.push_back({exp_mem[pushed], 2'b00});
                end
                pushed++;
            end else begin
                cmd_vld = 1'b0;
            end
        end
        @(negedge clk);
        check("burst_pushed", pushed, 9);
        check("burst_full", cmd_rdy, 0);
        cmd_wr = 1'b0; cmd_addr = 32'h38; cmd_vld = 1'b1;
        repeat (4) @(negedge clk);
        cmd_vld = 1'b0;
        check("burst_refused", cmd_rdy, 0);
        check("burst_stall_state", dbg_state, RESP);
        check("burst_hold_rdata", rsp_rdata, exp_q[0][33:2]);
        rsp_rdy = 1'b1;
        got  = 0;
        prev = 0;
        for (int k = 0; k < 200 && got < 9; k++) begin
            if (rsp_vld) begin
                e = exp_q.pop_front();
                check($sformatf("burst%0d_rsp", got), {rsp_rdata, rsp_err, rsp_tmo}, e);
                if (got > 0) check($sformatf("burst%0d_gap", got), cyc - prev, 4);
                prev = cyc;
                got++;
            end
            if (got < 9) @(negedge clk);
        end
        check("burst_count", got, 9);
        @(negedge clk);
        rsp_rdy = 1'b0;
        check("burst_busy_fall", busy, 0);
        check("burst_strobes", strobe_cnt - s0, 9);

        // ---- reset with one access in WAIT and three queued ----
        rmode = 2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_wr = 1'b0; cmd_addr = 32'(i * 4); cmd_vld = 1'b1;
        end
        @(negedge clk);
        cmd_vld = 1'b0;
        check("rst_pre_state", dbg_state, WAIT);
        check("rst_pre_busy", busy, 1);
        s0  = strobe_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("mid");
        rmode   = 0;
        vld_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_vld) vld_cnt++;
        end
        check("rst_no_rsp", vld_cnt, 0);
        check("rst_no_strobe", strobe_cnt - s0, 0);
        check("rst_post_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_bus_init_seq.md
# sys_bus_init_seq

Command-driven initiator (master) for the `sys_bus_if` system bus, driving register-array responders from a local controller. It buffers read/write commands in a small synchronous FIFO and issues them one at a time as single-cycle `wen`/`ren` strobes. It then waits for `ack`/`err`, or for a timeout, and returns one response per command over a valid/ready port.

## Interface
- `CD`, 8: command FIFO depth; power of 2, ≥2.
- `TW`, 16: timeout in WAIT cycles; 1..2^16-1.
- `clk`  in  1  system clock; same clock as `bus.clk`.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_vld`  in  1  command valid.
- `cmd_rdy`  out  1  FIFO not full.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  byte address.
- `cmd_wdata`  in  32  write data; ignored for reads.
- `rsp_vld`  out  1  response valid.
- `rsp_rdy`  in  1  response accepted.
- `rsp_rdata`  out  32  read data; 0 for writes, errors and timeouts.
- `rsp_err`  out  1  responder returned `err`.
- `rsp_tmo`  out  1  timeout expired.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `bus`  sys_bus_if.m  drives `addr`, `wdata`, `wen`, `ren`; samples `rdata`, `ack`, `err`.

## Operation
- Command handshake: a command is pushed when `cmd_vld & cmd_rdy`.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE → ISSUE when the FIFO is non-empty; the FIFO pops in the same cycle.
- ISSUE: `bus.wen` = `cmd_wr` or `bus.ren` = `!cmd_wr` for exactly one cycle. `addr`/`wdata` come from the popped entry and hold until the next ISSUE. `ack`/`err` are ignored in this cycle. Always → WAIT.
- WAIT: the first cycle with `ack | err` completes the transaction and moves to RESP.
  - `rsp_err` = `err`.
  - `rsp_rdata` = `bus.rdata` if read and `!err`, else 0.
- WAIT timeout: after TW WAIT cycles with no `ack`/`err`, → RESP with `rsp_tmo=1`, `rsp_err=0`, `rsp_rdata=0`. The counter clears in ISSUE.
- RESP: `rsp_vld=1`; response fields are stable until `rsp_rdy`. On `rsp_rdy` → IDLE.
- Only one transaction is outstanding. `ack`/`err` seen in IDLE or RESP are ignored, so a late ack after a timeout is dropped.
- Simultaneous push and pop on a full FIFO: the push is refused (`cmd_rdy=0`). Push and pop in the same cycle on a non-full FIFO are both honoured.
- FIFO pointers are `$clog2(CD)+1` bits wide and wrap naturally. Full = MSBs differ and LSBs equal.

## Timing
- Reset values:
  - `wen=ren=0`, `addr=wdata=0`
  - `rsp_vld=0`, `rsp_rdata=0`, `rsp_err=0`, `rsp_tmo=0`
  - `busy=0`, `cmd_rdy=1`
  - FIFO empty, FSM in IDLE.
- Reset in any state abandons the in-flight transaction and drops buffered commands. No response is produced for them.
- Latency against a one-cycle-ack responder:
  - command accepted at cycle N → IDLE→ISSUE at N+1
  - strobe at N+2
  - ack at N+3
  - `rsp_vld` at N+4
- Back-to-back throughput: one command per 4 cycles with `rsp_rdy` tied high.
- `busy` is registered. It falls the cycle after the last response handshake when the FIFO is empty.

## Configuration
- Macro: `SYS_BUS_INIT_TIMEOUT_EN`.
- Defined: timeout counter present; `rsp_tmo` behaves as above.
- Undefined: no counter; WAIT lasts until `ack`/`err`; `rsp_tmo` is constant 0; `TW` is unused.

## Structure
- Package `sys_bus_init_pkg`:
  - `cmd_t` struct {wr, addr[31:0], wdata[31:0]}
  - `rsp_t` struct {rdata[31:0], err, tmo}
  - `state_t` enum {IDLE, ISSUE, WAIT, RESP}
- Sub-module `sys_bus_init_fifo`: a generic synchronous FIFO of `cmd_t`, depth CD, with push/pop/full/empty and synchronous active-high reset.
- The top level holds the FSM, the timeout counter and the response register.

## Test plan
- Write 0x0000_0008 ← 0xDEAD_BEEF, responder acks 1 cycle later → strobe at N+2 with `addr`=0x8; `rsp_vld` at N+4 with `rdata=0`, `err=0`, `tmo=0`.
- Read 0x4 with responder returning 0x1234_5678 → `rsp_rdata`=0x1234_5678; exactly one `ren` pulse.
- Push 9 commands with CD=8 and `rsp_rdy=0` → `cmd_rdy` drops after 8 buffered; the FSM stalls in RESP holding the first response. Release `rsp_rdy` → all 9 responses arrive in order.
- Responder never acks, TW=16, macro defined → `rsp_tmo=1` after 16 WAIT cycles. An ack injected 3 cycles later is ignored. With the macro undefined, the FSM stays in WAIT.
- Responder asserts `err` on a read → `rsp_err=1`, `rsp_rdata=0`.
- `rst` pulsed during WAIT with 3 commands queued → all outputs return to reset values; `cmd_rdy=1`; no response is ever produced for those commands.
